// File: rtl/regfile_scoreboard_if.sv
// Register-file/scoreboard port bundle between decode, write-back and the file.
// master drives reads/issue/write-back/trigger; slave is the register file.
interface regfile_scoreboard_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int READ_PORTS    = 2
);
    localparam int NREG = 2 ** ADDRESS_WIDTH;

    logic [READ_PORTS*ADDRESS_WIDTH-1:0] rd_addr_i;
    logic [READ_PORTS*DATA_WIDTH-1:0]    rd_data_o;
    logic [READ_PORTS-1:0]               rd_busy_o;
    logic                                issue_valid_i;
    logic [ADDRESS_WIDTH-1:0]            issue_addr_i;
    logic                                wb_valid_i;
    logic [ADDRESS_WIDTH-1:0]            wb_addr_i;
    logic [DATA_WIDTH-1:0]               wb_data_i;
    logic                                trigger_i;
    logic [DATA_WIDTH-1:0]               a0_o;
    logic [NREG-1:0]                     busy_o;

    modport master (
        output rd_addr_i, issue_valid_i, issue_addr_i,
        output wb_valid_i, wb_addr_i, wb_data_i, trigger_i,
        input  rd_data_o, rd_busy_o, a0_o, busy_o
    );

    modport slave (
        input  rd_addr_i, issue_valid_i, issue_addr_i,
        input  wb_valid_i, wb_addr_i, wb_data_i, trigger_i,
        output rd_data_o, rd_busy_o, a0_o, busy_o
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with busy scoreboard, trigger write and a0 tap.
// Optional REGFILE_BYPASS_EN: forward same-cycle write-back/trigger to reads.
module regfile_scoreboard #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int READ_PORTS    = 2,
    parameter int TRIGGER_REG   = 5,
    parameter int A0_REG        = 10
) (
    input logic clk,
    input logic rst_n,
    regfile_scoreboard_if.slave bus
);
    localparam int AW   = ADDRESS_WIDTH;
    localparam int DW   = DATA_WIDTH;
    localparam int NREG = 2 ** AW;
    localparam logic [AW-1:0] LP_TRIG = AW'(TRIGGER_REG);
    localparam logic [AW-1:0] LP_A0   = AW'(A0_REG);

    logic [DW-1:0]            r_regs [NREG];
    logic [NREG-1:0]          r_busy;
    logic                     r_trig_q;

    logic                     w_trig_edge;
    logic [NREG-1:0]          w_busy_next;
    logic [AW-1:0]            w_addr;
    logic [READ_PORTS*DW-1:0] w_rd_data;
    logic [READ_PORTS-1:0]    w_rd_busy;

    assign w_trig_edge = bus.trigger_i & ~r_trig_q;

    // Next scoreboard: write-back clears first, issue sets after so it wins.
    always_comb begin
        w_busy_next = r_busy;
        if (bus.wb_valid_i)
            w_busy_next[bus.wb_addr_i] = 1'b0;
        if (bus.issue_valid_i && bus.issue_addr_i != '0)
            w_busy_next[bus.issue_addr_i] = 1'b1;
        w_busy_next[0] = 1'b0;
    end

    // Register array, scoreboard and trigger history; trigger beats write-back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
            r_busy   <= '0;
            r_trig_q <= 1'b0;
        end else begin
            r_trig_q <= bus.trigger_i;
            r_busy   <= w_busy_next;
            if (bus.wb_valid_i && bus.wb_addr_i != '0)
                r_regs[bus.wb_addr_i] <= bus.wb_data_i;
            if (w_trig_edge && LP_TRIG != '0)
                r_regs[LP_TRIG] <= DW'(1);
        end
    end

    // Combinational read ports, with optional same-cycle forwarding.
    always_comb begin
        w_rd_data = '0;
        w_rd_busy = '0;
        w_addr    = '0;
        for (int k = 0; k < READ_PORTS; k++) begin
            w_addr = bus.rd_addr_i[k*AW +: AW];
            if (w_addr != '0) begin
                w_rd_data[k*DW +: DW] = r_regs[w_addr];
                w_rd_busy[k]          = r_busy[w_addr];
`ifdef REGFILE_BYPASS_EN
                if (bus.wb_valid_i && bus.wb_addr_i == w_addr) begin
                    w_rd_data[k*DW +: DW] = bus.wb_data_i;
                    w_rd_busy[k] = bus.issue_valid_i &&
                                   bus.issue_addr_i == w_addr;
                end
                if (w_trig_edge && w_addr == LP_TRIG)
                    w_rd_data[k*DW +: DW] = DW'(1);
`endif
            end
        end
    end

    assign bus.rd_data_o = w_rd_data;
    assign bus.rd_busy_o = w_rd_busy;
    assign bus.a0_o      = r_regs[LP_A0];
    assign bus.busy_o    = r_busy;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed steps then random
// traffic compared to an array-based reference model.
module tb_regfile_scoreboard;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int RP = 4;
    localparam int NR = 32;
    localparam int TRIG = 5;
    localparam int A0 = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [DW-1:0] m_regs [NR];
    bit            m_busy [NR];
    bit            m_trig_q;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
                            .READ_PORTS(RP)) rif ();

    regfile_scoreboard #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
                         .READ_PORTS(RP), .TRIGGER_REG(TRIG),
                         .A0_REG(A0)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(rif.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_edge();
        return rif.trigger_i && !m_trig_q;
    endfunction

    function automatic logic [31:0] m_rd(input int a);
        if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (m_edge() && a == TRIG) return 32'h1;
        if (rif.wb_valid_i && int'(rif.wb_addr_i) == a) return rif.wb_data_i;
`endif
        return m_regs[a];
    endfunction

    function automatic logic m_rb(input int a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (rif.wb_valid_i && int'(rif.wb_addr_i) == a)
            return rif.issue_valid_i && int'(rif.issue_addr_i) == a;
`endif
        return m_busy[a];
    endfunction

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v;
        for (int i = 0; i < NR; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
            m_trig_q = 1'b0;
        end else begin
            if (rif.wb_valid_i && rif.wb_addr_i != 0)
                m_regs[rif.wb_addr_i] = rif.wb_data_i;
            if (m_edge()) m_regs[TRIG] = 32'h1;
            if (rif.wb_valid_i) m_busy[rif.wb_addr_i] = 1'b0;
            if (rif.issue_valid_i && rif.issue_addr_i != 0)
                m_busy[rif.issue_addr_i] = 1'b1;
            m_trig_q = rif.trigger_i;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rif.wb_valid_i    = 1'b0;
        rif.issue_valid_i = 1'b0;
    endtask

    task automatic set_port(input int k, input int a);
        rif.rd_addr_i[k*AW +: AW] = AW'(a);
    endtask

    task automatic check_all(input string tag);
        int a;
        #1;
        for (int k = 0; k < RP; k++) begin
            a = int'(rif.rd_addr_i[k*AW +: AW]);
            chk($sformatf("%s_data%0d", tag, k), rif.rd_data_o[k*DW +: DW], m_rd(a));
            chk($sformatf("%s_busy%0d", tag, k), 32'(rif.rd_busy_o[k]), 32'(m_rb(a)));
        end
        chk({tag, "_a0"}, rif.a0_o, m_regs[A0]);
        chk({tag, "_busyo"}, rif.busy_o, m_busy_vec());
    endtask

    initial begin
        rif.rd_addr_i = '0;
        rif.issue_valid_i = 1'b0;
        rif.issue_addr_i = '0;
        rif.wb_valid_i = 1'b0;
        rif.wb_addr_i = '0;
        rif.wb_data_i = '0;
        rif.trigger_i = 1'b0;
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = 32'hX;
            m_busy[i] = 1'b0;
        end
        m_trig_q = 1'b0;

        // reset with a concurrent write that must be discarded
        rst_n = 1'b0;
        rif.wb_valid_i = 1'b1;
        rif.wb_addr_i = 5'd3;
        rif.wb_data_i = 32'hAA;
        step();
        step();
        rst_n = 1'b1;
        idle();
        set_port(0, 3);
        #1;
        chk("rst_reg3", rif.rd_data_o[0 +: DW], 32'h0);
        chk("rst_busy", rif.busy_o, 32'h0);
        chk("rst_a0", rif.a0_o, 32'h0);
        check_all("rst");

        // write/read through a0 and port 1
        rif.wb_valid_i = 1'b1;
        rif.wb_addr_i = 5'd10;
        rif.wb_data_i = 32'hDEADBEEF;
        step();
        idle();
        set_port(1, 10);
        #1;
        chk("wr_a0", rif.a0_o, 32'hDEADBEEF);
        chk("wr_p1", rif.rd_data_o[DW +: DW], 32'hDEADBEEF);

        // write to x0 ignored
        rif.wb_valid_i = 1'b1;
        rif.wb_addr_i = 5'd0;
        rif.wb_data_i = 32'h1234;
        step();
        idle();
        set_port(0, 0);
        #1;
        chk("x0_read", rif.rd_data_o[0 +: DW], 32'h0);
        check_all("x0");

        // scoreboard: issue, issue+wb same cycle, wb alone
        rif.issue_valid_i = 1'b1;
        rif.issue_addr_i = 5'd7;
        step();
        idle();
        set_port(0, 7);
        #1;
        chk("sb_set", 32'(rif.rd_busy_o[0]), 32'h1);
        rif.issue_valid_i = 1'b1;
        rif.wb_valid_i = 1'b1;
        rif.wb_addr_i = 5'd7;
        rif.wb_data_i = 32'h77;
        step();
        idle();
        #1;
        chk("sb_setwins", 32'(rif.rd_busy_o[0]), 32'h1);
        rif.wb_valid_i = 1'b1;
        step();
        idle();
        #1;
        chk("sb_clear", 32'(rif.rd_busy_o[0]), 32'h0);
        check_all("sb");

        // trigger edge beats write-back, held level writes once
        set_port(0, 5);
        rif.trigger_i = 1'b1;
        rif.wb_valid_i = 1'b1;
        rif.wb_addr_i = 5'd5;
        rif.wb_data_i = 32'h55;
        step();
        idle();
        #1;
        chk("trg_first", rif.rd_data_o[0 +: DW], 32'h1);
        rif.wb_valid_i = 1'b1;
        rif.wb_data_i = 32'h9;
        step();
        idle();
        #1;
        chk("trg_held_wb", rif.rd_data_o[0 +: DW], 32'h9);
        step();
        step();
        chk("trg_held", rif.rd_data_o[0 +: DW], 32'h9);
        rif.trigger_i = 1'b0;
        step();
        rif.trigger_i = 1'b1;
        step();
        chk("trg_again", rif.rd_data_o[0 +: DW], 32'h1);
        check_all("trg");
        rif.trigger_i = 1'b0;

        // same-cycle forwarding (or lack of it) on port 0
        rif.wb_valid_i = 1'b1;
        rif.wb_addr_i = 5'd12;
        rif.wb_data_i = 32'h0BAD;
        step();
        idle();
        rif.issue_valid_i = 1'b1;
        rif.issue_addr_i = 5'd12;
        step();
        idle();
        set_port(0, 12);
        rif.wb_valid_i = 1'b1;
        rif.wb_addr_i = 5'd12;
        rif.wb_data_i = 32'hCAFE;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_data", rif.rd_data_o[0 +: DW], 32'hCAFE);
        chk("byp_busy", 32'(rif.rd_busy_o[0]), 32'h0);
`else
        chk("byp_data", rif.rd_data_o[0 +: DW], 32'h0BAD);
        chk("byp_busy", 32'(rif.rd_busy_o[0]), 32'h1);
`endif
        check_all("byp");
        step();
        idle();

        // four ports at once
        for (int i = 1; i <= 4; i++) begin
            rif.wb_valid_i = 1'b1;
            rif.wb_addr_i = AW'(i);
            rif.wb_data_i = 32'(i * 32'h11);
            step();
        end
        idle();
        for (int k = 0; k < RP; k++) set_port(k, k + 1);
        #1;
        chk("mp0", rif.rd_data_o[0*DW +: DW], 32'h11);
        chk("mp1", rif.rd_data_o[1*DW +: DW], 32'h22);
        chk("mp2", rif.rd_data_o[2*DW +: DW], 32'h33);
        chk("mp3", rif.rd_data_o[3*DW +: DW], 32'h44);

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            rif.wb_valid_i = $urandom_range(0, 1) == 1;
            rif.issue_valid_i = $urandom_range(0, 2) == 0;
            rif.wb_addr_i = ($urandom_range(0, 1) == 1) ?
                AW'($urandom_range(0, 12)) : AW'($urandom_range(0, 31));
            rif.issue_addr_i = ($urandom_range(0, 1) == 1) ?
                rif.wb_addr_i : AW'($urandom_range(0, 12));
            rif.wb_data_i = $urandom;
            rif.trigger_i = $urandom_range(0, 2) == 0;
            for (int k = 0; k < RP; k++) begin
                if ($urandom_range(0, 2) == 0) set_port(k, int'(rif.wb_addr_i));
                else set_port(k, $urandom_range(0, 12));
            end
            check_all("rnd");
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
